fft_frame_wr_ctrl: RTL and testbench
====================================

# fft_frame_wr_ctrl

Frame-aligned capture controller that writes the low bins of FFT modulus frames into a spectrum RAM. It sits between the FFT modulus stage and the dual-bank spectrum RAM, ahead of the frequency-separation logic. The block adds several behaviours beyond the original write controller:
- waits for a frame boundary before capturing;
- writes only valid samples;
- supports single-shot and continuous ping-pong capture;
- tracks the peak bin;
- flags malformed frames.

## Interface
- DATA_W, 16, modulus sample width
- FFT_LEN, 4096, bins per FFT frame (power of two)
- STORE_LEN, 2048, bins written per frame (bins 0..STORE_LEN-1, power of two, ≤ FFT_LEN)
- PEAK_MIN_BIN, 1, lowest bin eligible for peak search (1 excludes DC)

Ports:
- clk  in  1  FFT clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle arm pulse
- stop  in  1  one-cycle abort pulse
- cont_mode  in  1  0 = single frame, 1 = continuous ping-pong; sampled on accepted start
- din  in  DATA_W  modulus sample
- din_valid  in  1  sample valid
- din_last  in  1  qualifies the last bin of a frame when din_valid=1
- wr_data  out  DATA_W  RAM write data
- wr_addr  out  $clog2(STORE_LEN)  RAM write address (bin index)
- wr_bank  out  1  RAM bank being written
- wr_en  out  1  RAM write enable
- busy  out  1  high in any state except IDLE and DONE
- done  out  1  level; single-mode frame captured, cleared by next accepted start
- frame_done  out  1  one-cycle pulse per completed frame (both modes)
- rd_bank  out  1  bank holding the most recent complete frame
- peak_val  out  DATA_W  maximum modulus of the last complete frame
- peak_bin  out  $clog2(STORE_LEN)  bin index of peak_val
- err  out  1  sticky frame-length error; cleared by accepted start

## Operation
- States: IDLE, SYNC, CAPTURE, SKIP, DONE.
- IDLE: start → SYNC. Start also latches cont_mode and clears done and err.
- SYNC: discard samples until din_valid & din_last, then → CAPTURE with bin counter 0. The next valid sample is bin 0.
- CAPTURE: each valid sample writes din at wr_addr = bin, bank = wr_bank, and increments bin.
  - Bin STORE_LEN-1 written → SKIP. If STORE_LEN = FFT_LEN, frame ends here.
- SKIP: count valid samples without writing. Frame end is the sample with din_last at bin FFT_LEN-1.
- Frame end, single mode → DONE: done=1, rd_bank=wr_bank, frame_done pulse, peak outputs updated.
- Frame end, continuous mode → CAPTURE bin 0: rd_bank=wr_bank, wr_bank toggles, frame_done pulse, peak outputs updated.
- DONE: start → SYNC.
- Short frame (din_last before bin FFT_LEN-1): set err, drop the frame (no frame_done, no bank toggle, peak not updated), restart CAPTURE at bin 0.
- Long frame (bin FFT_LEN-1 without din_last): set err, drop the frame → SYNC.
- stop in any state → IDLE next cycle; done and peak outputs unchanged. stop and start in the same cycle: stop wins.
- start while busy: ignored.
- din_valid low: state, bin and peak search hold; wr_en=0.
- Peak search: over bins PEAK_MIN_BIN..STORE_LEN-1, strict greater-than (ties keep the lowest bin). The running max resets at each frame start.
- Arithmetic: unsigned compare. Bin counter width is $clog2(FFT_LEN) and wraps only via the end-of-frame rule.

## Timing
- wr_data, wr_addr, wr_en and wr_bank are registered: 1 cycle after the accepted din_valid. wr_en is a single-cycle pulse per written bin.
- frame_done, done, rd_bank, peak_val and peak_bin update in the same cycle as the wr_en of the final stored bin, or 1 cycle after the frame-end sample if STORE_LEN < FFT_LEN.
- Full throughput: one sample per clock, no back-pressure.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, wr_bank=0, rd_bank=0, busy=0, done=0, frame_done=0, peak_val=0, peak_bin=0, err=0, state IDLE.
- Reset mid-frame: all of the above are asserted asynchronously. Capture resumes only after a new start, via SYNC.

## Structure
- Package fft_cap_pkg: state enumeration, derived widths (BIN_W=$clog2(FFT_LEN), ADDR_W=$clog2(STORE_LEN)).
- Sub-module peak_tracker: running max and arg-max with clear/enable/commit inputs. Instantiated once.
- Remaining logic: one FSM plus counter/bank registers in the top.

## Test plan
- Reset, start, then feed two frames (FFT_LEN=4096, din=bin index, last at 4095) → first frame ignored (SYNC). Second frame: 2048 wr_en pulses with addr 0..2047, data = addr; done=1; peak_val=2047, peak_bin=2047.
- Continuous mode, 3 frames → frame_done pulses ×3; wr_bank sequence 0,1,0; rd_bank follows the completed bank.
- din_valid toggled randomly at 50% → same written contents and addresses as gapless; no wr_en in gaps.
- din_last at bin 1000 → err=1, no frame_done. Next well-formed frame captured from bin 0.
- Equal peaks 500 at bins 0, 10 and 300 → peak_bin=10 (DC excluded, tie keeps lowest).
- Assert rst at bin 700 of a capture → all outputs at reset values immediately; start after release → SYNC, clean capture.

Source files
------------

// File: rtl/fft_cap_pkg.sv
// Shared types and default geometry for the FFT frame capture controller.
package fft_cap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_CAPTURE,
    ST_SKIP,
    ST_DONE
  } cap_state_e;

  localparam int FFT_LEN_DEF   = 4096;
  localparam int STORE_LEN_DEF = 2048;
  localparam int BIN_W         = $clog2(FFT_LEN_DEF);
  localparam int ADDR_W        = $clog2(STORE_LEN_DEF);

endpackage

// File: rtl/fft_frame_wr_ctrl_peak_tracker.sv
// Running maximum / arg-max of one frame, published to the outputs on commit.
module peak_tracker #(
  parameter int DATA_W = 16,
  parameter int BIN_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              commit,
  input  logic [DATA_W-1:0] din,
  input  logic [BIN_W-1:0]  bin,
  output logic [DATA_W-1:0] peak_val,
  output logic [BIN_W-1:0]  peak_bin
);

  logic              run_vld_q, run_vld_d;
  logic [DATA_W-1:0] run_val_q, run_val_d;
  logic [BIN_W-1:0]  run_bin_q, run_bin_d;
  logic [DATA_W-1:0] peak_val_q, peak_val_d;
  logic [BIN_W-1:0]  peak_bin_q, peak_bin_d;

  logic              base_vld;
  logic [DATA_W-1:0] base_val;
  logic [BIN_W-1:0]  base_bin;
  logic              take;
  logic              nxt_vld;
  logic [DATA_W-1:0] nxt_val;
  logic [BIN_W-1:0]  nxt_bin;

  always_comb begin
    // clr starts a new frame: the current sample competes against an empty history
    base_vld = clr ? 1'b0 : run_vld_q;
    base_val = clr ? '0 : run_val_q;
    base_bin = clr ? '0 : run_bin_q;
    take     = en && (!base_vld || (din > base_val));
    nxt_vld  = base_vld | take;
    nxt_val  = take ? din : base_val;
    nxt_bin  = take ? bin : base_bin;

    run_vld_d  = run_vld_q;
    run_val_d  = run_val_q;
    run_bin_d  = run_bin_q;
    peak_val_d = peak_val_q;
    peak_bin_d = peak_bin_q;
    if (clr || en) begin
      run_vld_d = nxt_vld;
      run_val_d = nxt_val;
      run_bin_d = nxt_bin;
    end
    if (commit) begin
      peak_val_d = nxt_val;
      peak_bin_d = nxt_bin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_vld_q  <= 1'b0;
      run_val_q  <= '0;
      run_bin_q  <= '0;
      peak_val_q <= '0;
      peak_bin_q <= '0;
    end else begin
      run_vld_q  <= run_vld_d;
      run_val_q  <= run_val_d;
      run_bin_q  <= run_bin_d;
      peak_val_q <= peak_val_d;
      peak_bin_q <= peak_bin_d;
    end
  end

  assign peak_val = peak_val_q;
  assign peak_bin = peak_bin_q;

endmodule

// File: rtl/fft_frame_wr_ctrl.sv
// Frame-aligned capture of the low FFT bins into a dual-bank spectrum RAM,
// with single-shot / ping-pong modes, peak tracking and frame-length checking.
module fft_frame_wr_ctrl
  import fft_cap_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int FFT_LEN      = FFT_LEN_DEF,
  parameter int STORE_LEN    = STORE_LEN_DEF,
  parameter int PEAK_MIN_BIN = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         cont_mode,
  input  logic [DATA_W-1:0]            din,
  input  logic                         din_valid,
  input  logic                         din_last,
  output logic [DATA_W-1:0]            wr_data,
  output logic [$clog2(STORE_LEN)-1:0] wr_addr,
  output logic                         wr_bank,
  output logic                         wr_en,
  output logic                         busy,
  output logic                         done,
  output logic                         frame_done,
  output logic                         rd_bank,
  output logic [DATA_W-1:0]            peak_val,
  output logic [$clog2(STORE_LEN)-1:0] peak_bin,
  output logic                         err
);

  localparam int BW = $clog2(FFT_LEN);
  localparam int AW = $clog2(STORE_LEN);
  localparam logic [BW-1:0] LAST_BIN  = BW'(FFT_LEN - 1);
  localparam logic [BW-1:0] STORE_END = BW'(STORE_LEN - 1);
  localparam logic [BW-1:0] PK_MIN    = BW'(PEAK_MIN_BIN);

  cap_state_e        state_q, state_d;
  logic [BW-1:0]     bin_q, bin_d;
  logic              cont_q, cont_d;
  logic              bank_q, bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              wr_en_q, wr_en_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_bank_q, wr_bank_d;

  logic step;
  logic frame_end;
  logic pk_clr, pk_en, pk_commit;

  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    cont_d       = cont_q;
    bank_d       = bank_q;
    rd_bank_d    = rd_bank_q;
    done_d       = done_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_bank_d    = wr_bank_q;
    step         = 1'b0;
    frame_end    = 1'b0;
    pk_clr       = 1'b0;
    pk_en        = 1'b0;
    pk_commit    = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_SYNC;
            cont_d  = cont_mode;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
        ST_SYNC: begin
          if (din_valid && din_last) begin
            state_d = ST_CAPTURE;
            bin_d   = '0;
          end
        end
        ST_CAPTURE: begin
          if (din_valid) begin
            step      = 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = bin_q[AW-1:0];
            wr_data_d = din;
            wr_bank_d = bank_q;
            pk_clr    = (bin_q == '0);
            pk_en     = (bin_q >= PK_MIN);
          end
        end
        ST_SKIP: begin
          step = din_valid;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Frame-length bookkeeping shared by CAPTURE and SKIP
    if (step) begin
      if (bin_q == LAST_BIN) begin
        if (din_last) begin
          frame_end = 1'b1;
        end else begin
          err_d   = 1'b1;
          state_d = ST_SYNC;
        end
      end else if (din_last) begin
        err_d   = 1'b1;
        state_d = ST_CAPTURE;
        bin_d   = '0;
      end else begin
        bin_d = bin_q + 1'b1;
        if ((state_q == ST_CAPTURE) && (bin_q == STORE_END)) begin
          state_d = ST_SKIP;
        end
      end
    end

    if (frame_end) begin
      frame_done_d = 1'b1;
      rd_bank_d    = bank_q;
      pk_commit    = 1'b1;
      bin_d        = '0;
      if (cont_q) begin
        state_d = ST_CAPTURE;
        bank_d  = ~bank_q;
      end else begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end

    busy_d = !((state_d == ST_IDLE) || (state_d == ST_DONE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bin_q        <= '0;
      cont_q       <= 1'b0;
      bank_q       <= 1'b0;
      rd_bank_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_bank_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      cont_q       <= cont_d;
      bank_q       <= bank_d;
      rd_bank_q    <= rd_bank_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_bank_q    <= wr_bank_d;
    end
  end

  peak_tracker #(
    .DATA_W (DATA_W),
    .BIN_W  (AW)
  ) u_peak (
    .clk      (clk),
    .rst      (rst),
    .clr      (pk_clr),
    .en       (pk_en),
    .commit   (pk_commit),
    .din      (din),
    .bin      (bin_q[AW-1:0]),
    .peak_val (peak_val),
    .peak_bin (peak_bin)
  );

  assign wr_data    = wr_data_q;
  assign wr_addr    = wr_addr_q;
  assign wr_bank    = wr_bank_q;
  assign wr_en      = wr_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign frame_done = frame_done_q;
  assign rd_bank    = rd_bank_q;
  assign err        = err_q;

endmodule

// File: tb/tb_fft_frame_wr_ctrl.sv
// Directed-sequence bench with random frame data, checked against a frame-level model.
module tb_fft_frame_wr_ctrl;

  localparam int DATA_W    = 16;
  localparam int FFT_LEN   = 4096;
  localparam int STORE_LEN = 2048;
  localparam int PK_MIN    = 1;
  localparam int AW        = $clog2(STORE_LEN);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              cont_mode = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              din_last = 1'b0;
  logic [DATA_W-1:0] wr_data;
  logic [AW-1:0]     wr_addr;
  logic              wr_bank;
  logic              wr_en;
  logic              busy;
  logic              done;
  logic              frame_done;
  logic              rd_bank;
  logic [DATA_W-1:0] peak_val;
  logic [AW-1:0]     peak_bin;
  logic              err;

  fft_frame_wr_ctrl #(
    .DATA_W       (DATA_W),
    .FFT_LEN      (FFT_LEN),
    .STORE_LEN    (STORE_LEN),
    .PEAK_MIN_BIN (PK_MIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .cont_mode  (cont_mode),
    .din        (din),
    .din_valid  (din_valid),
    .din_last   (din_last),
    .wr_data    (wr_data),
    .wr_addr    (wr_addr),
    .wr_bank    (wr_bank),
    .wr_en      (wr_en),
    .busy       (busy),
    .done       (done),
    .frame_done (frame_done),
    .rd_bank    (rd_bank),
    .peak_val   (peak_val),
    .peak_bin   (peak_bin),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int bank;
  } wr_t;

  wr_t         wq[$];
  int          fd_count = 0;
  int          compared = 0;
  int          mism = 0;
  logic [15:0] fdata[FFT_LEN];

  always @(negedge clk) begin
    if (wr_en === 1'b1) wq.push_back('{int'(wr_addr), int'(wr_data), int'(wr_bank)});
    if (frame_done === 1'b1) fd_count++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic mode);
    start = 1'b1;
    cont_mode = mode;
    tick();
    start = 1'b0;
    cont_mode = 1'b0;
  endtask

  // Drive a frame from fdata; last_at < 0 means no din_last at all.
  task automatic send_frame(input int n, input int last_at, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        din_valid = 1'b0;
        din = 16'($urandom);
        din_last = 1'($urandom);
        tick();
      end
      din_valid = 1'b1;
      din = fdata[i];
      din_last = (i == last_at);
      tick();
    end
    din_valid = 1'b0;
    din_last = 1'b0;
  endtask

  task automatic sync_pulse();
    for (int i = 0; i < 4; i++) begin
      din_valid = 1'b1;
      din = 16'($urandom);
      din_last = (i == 3);
      tick();
    end
    din_valid = 1'b0;
    din_last = 1'b0;
  endtask

  task automatic fill_random(input int maxv);
    for (int i = 0; i < FFT_LEN; i++) fdata[i] = 16'($urandom_range(maxv, 0));
  endtask

  // Expected peak: highest value among eligible stored bins, earliest bin on ties.
  task automatic model_peak(output int pv, output int pb);
    pv = -1;
    pb = 0;
    for (int b = PK_MIN; b < STORE_LEN; b++) begin
      if (int'(fdata[b]) > pv) begin
        pv = int'(fdata[b]);
        pb = b;
      end
    end
  endtask

  task automatic check_capture(input string tag, input int exp_bank, input int n_exp);
    int bad;
    int n;
    bad = 0;
    chk({tag, "_wr_count"}, wq.size(), n_exp);
    n = (wq.size() < n_exp) ? wq.size() : n_exp;
    for (int i = 0; i < n; i++) begin
      if (wq[i].addr != i || wq[i].data != int'(fdata[i]) || wq[i].bank != exp_bank) bad++;
    end
    chk({tag, "_wr_bad_entries"}, bad, 0);
    wq.delete();
  endtask

  task automatic check_frame_end(input string tag, input int exp_rd_bank);
    int pv;
    int pb;
    model_peak(pv, pb);
    chk({tag, "_frame_done"}, 32'(frame_done), 1);
    chk({tag, "_rd_bank"}, 32'(rd_bank), exp_rd_bank);
    chk({tag, "_peak_val"}, 32'(peak_val), pv);
    chk({tag, "_peak_bin"}, 32'(peak_bin), pb);
  endtask

  int mbank;
  int fd_base;
  int keep_pv;
  int keep_pb;

  initial begin
    mbank = 0;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_flags", 32'({wr_bank, rd_bank, busy, done, frame_done, err}), 0);
    chk("rst_peak", 32'({peak_val, peak_bin}), 0);
    rst = 1'b0;
    tick();

    // Single shot, din = bin index: first frame only aligns
    for (int i = 0; i < FFT_LEN; i++) fdata[i] = 16'(i);
    pulse_start(1'b0);
    chk("t1_busy_after_start", 32'(busy), 1);
    send_frame(FFT_LEN, FFT_LEN - 1, 0);
    tick();
    chk("t1_no_write_in_sync", wq.size(), 0);
    send_frame(FFT_LEN, FFT_LEN - 1, 0);
    chk("t1_frame_done", 32'(frame_done), 1);
    chk("t1_done", 32'(done), 1);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_peak_val", 32'(peak_val), 2047);
    chk("t1_peak_bin", 32'(peak_bin), 2047);
    chk("t1_err", 32'(err), 0);
    tick();
    chk("t1_frame_done_pulse", 32'(frame_done), 0);
    check_capture("t1", 0, STORE_LEN);
    chk("t1_fd_count", fd_count, 1);

    // Continuous ping-pong, three frames
    pulse_start(1'b1);
    chk("t2_done_cleared", 32'(done), 0);
    sync_pulse();
    for (int f = 0; f < 3; f++) begin
      fill_random(65535);
      send_frame(FFT_LEN, FFT_LEN - 1, 0);
      check_frame_end($sformatf("t2_f%0d", f), mbank);
      tick();
      check_capture($sformatf("t2_f%0d", f), mbank, STORE_LEN);
      mbank ^= 1;
    end
    chk("t2_fd_count", fd_count, 4);
    chk("t2_busy_running", 32'(busy), 1);
    keep_pv = int'(peak_val);
    keep_pb = int'(peak_bin);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t2_stop_busy", 32'(busy), 0);
    chk("t2_stop_done", 32'(done), 0);
    chk("t2_stop_peak", 32'({peak_val, peak_bin}), 32'({16'(keep_pv), 11'(keep_pb)}));

    // 50% random valid gaps
    pulse_start(1'b0);
    sync_pulse();
    fill_random(65535);
    send_frame(FFT_LEN, FFT_LEN - 1, 50);
    check_frame_end("t3", mbank);
    chk("t3_done", 32'(done), 1);
    tick();
    check_capture("t3", mbank, STORE_LEN);

    // Short frame: last at bin 1000
    pulse_start(1'b0);
    sync_pulse();
    fd_base = fd_count;
    fill_random(65535);
    send_frame(1001, 1000, 0);
    tick();
    chk("t4_short_err", 32'(err), 1);
    chk("t4_short_no_fd", fd_count, fd_base);
    chk("t4_short_busy", 32'(busy), 1);
    check_capture("t4_short", mbank, 1001);
    fill_random(65535);
    send_frame(FFT_LEN, FFT_LEN - 1, 0);
    check_frame_end("t4_next", mbank);
    chk("t4_err_sticky", 32'(err), 1);
    chk("t4_done", 32'(done), 1);
    tick();
    check_capture("t4_next", mbank, STORE_LEN);

    // Long frame: no din_last at bin FFT_LEN-1
    pulse_start(1'b0);
    chk("t4_err_cleared", 32'(err), 0);
    sync_pulse();
    fd_base = fd_count;
    fill_random(65535);
    send_frame(FFT_LEN, -1, 0);
    tick();
    chk("t4_long_err", 32'(err), 1);
    chk("t4_long_no_fd", fd_count, fd_base);
    check_capture("t4_long", mbank, STORE_LEN);
    sync_pulse();
    fill_random(65535);
    send_frame(FFT_LEN, FFT_LEN - 1, 0);
    check_frame_end("t4_relock", mbank);
    tick();
    check_capture("t4_relock", mbank, STORE_LEN);

    // Equal peaks at 0, 10, 300; start while busy is ignored
    pulse_start(1'b0);
    sync_pulse();
    pulse_start(1'b1);
    chk("t5_busy_start_ignored", 32'(busy), 1);
    fill_random(499);
    fdata[0] = 16'd500;
    fdata[10] = 16'd500;
    fdata[300] = 16'd500;
    send_frame(FFT_LEN, FFT_LEN - 1, 0);
    chk("t5_done_single", 32'(done), 1);
    chk("t5_peak_val", 32'(peak_val), 500);
    chk("t5_peak_bin", 32'(peak_bin), 10);
    tick();
    check_capture("t5", mbank, STORE_LEN);

    // Asynchronous reset at bin 700
    pulse_start(1'b0);
    sync_pulse();
    fill_random(65535);
    send_frame(700, -1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_wr", 32'({wr_en, wr_bank, wr_addr}), 0);
    chk("t6_rst_wr_data", 32'(wr_data), 0);
    chk("t6_rst_flags", 32'({rd_bank, busy, done, frame_done, err}), 0);
    chk("t6_rst_peak", 32'({peak_val, peak_bin}), 0);
    tick();
    tick();
    rst = 1'b0;
    wq.delete();
    mbank = 0;
    sync_pulse();
    send_frame(20, 19, 0);
    tick();
    chk("t6_idle_no_write", wq.size(), 0);
    chk("t6_idle_busy", 32'(busy), 0);
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("t6_stop_wins", 32'(busy), 0);
    pulse_start(1'b0);
    sync_pulse();
    fill_random(65535);
    send_frame(FFT_LEN, FFT_LEN - 1, 0);
    check_frame_end("t6_clean", 0);
    chk("t6_done", 32'(done), 1);
    tick();
    check_capture("t6_clean", 0, STORE_LEN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
